// File: rtl/mul_wb_buf.sv
// Multiplier writeback buffer.
// The ALU always owns the register-file write port when it asks for it.
// Multiplier results that lose arbitration wait in a small in-order FIFO and
// retire when the port is free. A result goes straight to the port only when
// nothing older is waiting, so results always retire in arrival order.
// mul_stall_out is decoded from registered occupancy alone, which gives issue
// logic SLACK cycles of margin for ops already in the pipeline.
module mul_wb_buf #(
   parameter int DEPTH = 4,
   parameter int SLACK = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush,
   input  logic                     mul_en_in,
   input  logic [4:0]               mul_rd_in,
   input  logic [31:0]              mul_result_in,
   input  logic                     alu_en_in,
   input  logic [4:0]               alu_rd_in,
   input  logic [31:0]              alu_result_in,
   output logic                     wb_en_out,
   output logic [4:0]               wb_rd_out,
   output logic [31:0]              wb_data_out,
   output logic                     mul_stall_out,
   output logic [$clog2(DEPTH):0]   count_out,
   output logic                     overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [4:0]    mem_rd   [DEPTH];
   logic [31:0]   mem_data [DEPTH];

   logic cand;
   logic fifo_empty;
   logic fifo_full;
   logic sel_fifo;
   logic sel_byp;
   logic push_req;
   logic push_drop;
   logic push;

   // Port arbitration and FIFO push/pop decisions for this cycle.
   // A flush kills both the incoming candidate and any pop, so no pending
   // multiplier result reaches the port in the flush cycle.
   always_comb begin
      cand       = mul_en_in && (mul_rd_in != 5'd0) && !flush;
      fifo_empty = (count == '0);
      fifo_full  = (count == CW'(DEPTH));
      sel_fifo   = !alu_en_in && !fifo_empty && !flush;
      sel_byp    = !alu_en_in && fifo_empty && cand;
      push_req   = cand && !sel_byp;
      // When full, a push only fits if the head leaves in the same edge.
      push_drop  = push_req && fifo_full && !sel_fifo;
      push       = push_req && !push_drop;
   end

   // Pointer, occupancy and sticky overflow state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (push_drop)
            overflow_err <= 1'b1;
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push)
               tail <= tail + PW'(1);
            if (sel_fifo)
               head <= head + PW'(1);
            count <= count + CW'(push) - CW'(sel_fifo);
         end
      end
   end

   // FIFO payload storage; contents are meaningless outside head..tail.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[tail]   <= mul_rd_in;
         mem_data[tail] <= mul_result_in;
      end
   end

   // Registered write port: ALU, then oldest queued result, then bypass.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb_en_out   <= 1'b0;
         wb_rd_out   <= 5'd0;
         wb_data_out <= 32'd0;
      end else if (alu_en_in) begin
         wb_en_out   <= (alu_rd_in != 5'd0);
         wb_rd_out   <= alu_rd_in;
         wb_data_out <= alu_result_in;
      end else if (sel_fifo) begin
         wb_en_out   <= 1'b1;
         wb_rd_out   <= mem_rd[head];
         wb_data_out <= mem_data[head];
      end else if (sel_byp) begin
         wb_en_out   <= 1'b1;
         wb_rd_out   <= mul_rd_in;
         wb_data_out <= mul_result_in;
      end else begin
         wb_en_out   <= 1'b0;
      end
   end

   // Stall depends only on registered occupancy, never on inputs.
   always_comb begin
      count_out     = count;
      mul_stall_out = (count >= CW'(DEPTH - SLACK));
   end

endmodule

// File: tb/tb_mul_wb_buf.sv
// Scoreboard bench for mul_wb_buf (DEPTH=4, SLACK=2).
// Directed stimulus pushes the hand-derived write sequence into a queue; a
// monitor pops and compares on every register-file write.
module tb_mul_wb_buf;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush;
   logic        mul_en_in;
   logic [4:0]  mul_rd_in;
   logic [31:0] mul_result_in;
   logic        alu_en_in;
   logic [4:0]  alu_rd_in;
   logic [31:0] alu_result_in;
   logic        wb_en_out;
   logic [4:0]  wb_rd_out;
   logic [31:0] wb_data_out;
   logic        mul_stall_out;
   logic [2:0]  count_out;
   logic        overflow_err;

   int total = 0;
   int bad   = 0;
   logic [36:0] sb [$];

   mul_wb_buf #(.DEPTH(4), .SLACK(2)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .flush         (flush),
      .mul_en_in     (mul_en_in),
      .mul_rd_in     (mul_rd_in),
      .mul_result_in (mul_result_in),
      .alu_en_in     (alu_en_in),
      .alu_rd_in     (alu_rd_in),
      .alu_result_in (alu_result_in),
      .wb_en_out     (wb_en_out),
      .wb_rd_out     (wb_rd_out),
      .wb_data_out   (wb_data_out),
      .mul_stall_out (mul_stall_out),
      .count_out     (count_out),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_wr(input logic [4:0] rd, input logic [31:0] data);
      sb.push_back({rd, data});
   endtask

   // Drive one cycle of inputs, return at the following falling edge.
   task automatic step(input logic ae, input logic [4:0] ard, input logic [31:0] ad,
                       input logic me, input logic [4:0] mrd, input logic [31:0] md,
                       input logic fl);
      alu_en_in     = ae;
      alu_rd_in     = ard;
      alu_result_in = ad;
      mul_en_in     = me;
      mul_rd_in     = mrd;
      mul_result_in = md;
      flush         = fl;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_wb_en"}, 32'(wb_en_out), 32'd0);
      chk({tag, "_wb_rd"}, 32'(wb_rd_out), 32'd0);
      chk({tag, "_wb_data"}, wb_data_out, 32'd0);
      chk({tag, "_count"}, 32'(count_out), 32'd0);
      chk({tag, "_stall"}, 32'(mul_stall_out), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow_err), 32'd0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      rstn = 1'b1;
   endtask

   // Monitor: every register-file write must match the oldest expectation.
   always @(negedge clk) begin
      if (rstn === 1'b1 && wb_en_out === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no write",
                     wb_rd_out, wb_data_out);
         end else begin
            logic [36:0] e;
            e = sb.pop_front();
            if ({wb_rd_out, wb_data_out} !== e) begin
               bad++;
               $display("FAIL wb_write: got rd=%0d data=%0h expected rd=%0d data=%0h",
                        wb_rd_out, wb_data_out, e[36:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      flush = 1'b0;
      mul_en_in = 1'b0; mul_rd_in = 5'd0; mul_result_in = 32'd0;
      alu_en_in = 1'b0; alu_rd_in = 5'd0; alu_result_in = 32'd0;
      @(negedge clk);
      do_reset();

      // Bypass: empty FIFO, ALU idle.
      exp_wr(5'd5, 32'h12345678);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678, 1'b0);
      chk("byp_wb_en", 32'(wb_en_out), 32'd1);
      chk("byp_count", 32'(count_out), 32'd0);
      idle();
      chk("byp_after_en", 32'(wb_en_out), 32'd0);

      // Contention: ALU wins three cycles, multiplier results queue then drain in order.
      exp_wr(5'd3, 32'h100); exp_wr(5'd3, 32'h101); exp_wr(5'd3, 32'h102);
      exp_wr(5'd7, 32'hA);   exp_wr(5'd8, 32'hB);   exp_wr(5'd9, 32'hC);
      step(1'b1, 5'd3, 32'h100, 1'b1, 5'd7, 32'hA, 1'b0);
      chk("cont_count1", 32'(count_out), 32'd1);
      chk("cont_stall1", 32'(mul_stall_out), 32'd0);
      step(1'b1, 5'd3, 32'h101, 1'b1, 5'd8, 32'hB, 1'b0);
      chk("cont_count2", 32'(count_out), 32'd2);
      chk("cont_stall2", 32'(mul_stall_out), 32'd1);
      step(1'b1, 5'd3, 32'h102, 1'b1, 5'd9, 32'hC, 1'b0);
      chk("cont_count3", 32'(count_out), 32'd3);
      chk("cont_stall3", 32'(mul_stall_out), 32'd1);
      idle();
      chk("cont_drain_rd7", 32'(wb_rd_out), 32'd7);
      chk("cont_count_d1", 32'(count_out), 32'd2);
      chk("cont_stall_d1", 32'(mul_stall_out), 32'd1);
      idle();
      chk("cont_count_d2", 32'(count_out), 32'd1);
      chk("cont_stall_d2", 32'(mul_stall_out), 32'd0);
      idle();
      chk("cont_count_d3", 32'(count_out), 32'd0);
      chk("cont_drain_rd9", 32'(wb_rd_out), 32'd9);
      idle();
      chk("cont_idle_en", 32'(wb_en_out), 32'd0);

      // rd=0 results and rd=0 ALU writes never reach the port.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
      chk("rd0_mul_en", 32'(wb_en_out), 32'd0);
      chk("rd0_mul_count", 32'(count_out), 32'd0);
      step(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("rd0_alu_en", 32'(wb_en_out), 32'd0);

      // Flush with three queued results plus a same-cycle candidate; ALU still writes.
      exp_wr(5'd1, 32'h31); exp_wr(5'd1, 32'h32); exp_wr(5'd1, 32'h33);
      exp_wr(5'd2, 32'h22);
      step(1'b1, 5'd1, 32'h31, 1'b1, 5'd10, 32'h10, 1'b0);
      step(1'b1, 5'd1, 32'h32, 1'b1, 5'd11, 32'h11, 1'b0);
      step(1'b1, 5'd1, 32'h33, 1'b1, 5'd12, 32'h12, 1'b0);
      chk("fl_pre_count", 32'(count_out), 32'd3);
      step(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44, 1'b1);
      chk("fl_count", 32'(count_out), 32'd0);
      chk("fl_stall", 32'(mul_stall_out), 32'd0);
      chk("fl_alu_rd", 32'(wb_rd_out), 32'd2);
      idle();
      chk("fl_no_mul_wr", 32'(wb_en_out), 32'd0);
      idle();
      chk("fl_no_mul_wr2", 32'(wb_en_out), 32'd0);

      // Overflow: full FIFO, ALU busy, new candidate is dropped and error sticks.
      exp_wr(5'd1, 32'h41); exp_wr(5'd1, 32'h42); exp_wr(5'd1, 32'h43);
      exp_wr(5'd1, 32'h44); exp_wr(5'd1, 32'h45);
      exp_wr(5'd13, 32'hD0); exp_wr(5'd14, 32'hD1);
      exp_wr(5'd15, 32'hD2); exp_wr(5'd16, 32'hD3);
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'd1, 32'h41 + 32'(i), 1'b1, 5'd13 + 5'(i), 32'hD0 + 32'(i), 1'b0);
      chk("ovf_fill_count", 32'(count_out), 32'd4);
      chk("ovf_fill_err", 32'(overflow_err), 32'd0);
      step(1'b1, 5'd1, 32'h45, 1'b1, 5'd17, 32'hE0, 1'b0);
      chk("ovf_err_set", 32'(overflow_err), 32'd1);
      chk("ovf_count_sat", 32'(count_out), 32'd4);
      for (int i = 0; i < 5; i++) idle();
      chk("ovf_drained", 32'(count_out), 32'd0);
      chk("ovf_err_sticky", 32'(overflow_err), 32'd1);
      chk("ovf_sb_empty", 32'(sb.size()), 32'd0);

      // Clear the sticky error, then full FIFO with ALU idle: pop plus push.
      @(negedge clk);
      do_reset();
      exp_wr(5'd1, 32'h51); exp_wr(5'd1, 32'h52); exp_wr(5'd1, 32'h53);
      exp_wr(5'd1, 32'h54);
      exp_wr(5'd13, 32'hD0); exp_wr(5'd14, 32'hD1);
      exp_wr(5'd15, 32'hD2); exp_wr(5'd16, 32'hD3); exp_wr(5'd20, 32'hF0);
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'd1, 32'h51 + 32'(i), 1'b1, 5'd13 + 5'(i), 32'hD0 + 32'(i), 1'b0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hF0, 1'b0);
      chk("full_noalu_head", 32'(wb_rd_out), 32'd13);
      chk("full_noalu_count", 32'(count_out), 32'd4);
      chk("full_noalu_err", 32'(overflow_err), 32'd0);
      for (int i = 0; i < 5; i++) idle();
      chk("full_noalu_drain", 32'(count_out), 32'd0);

      // Asynchronous reset between edges with two queued results and a live write.
      exp_wr(5'd1, 32'h61); exp_wr(5'd1, 32'h62);
      step(1'b1, 5'd1, 32'h61, 1'b1, 5'd21, 32'h71, 1'b0);
      step(1'b1, 5'd1, 32'h62, 1'b1, 5'd22, 32'h72, 1'b0);
      chk("ar_pre_count", 32'(count_out), 32'd2);
      chk("ar_pre_en", 32'(wb_en_out), 32'd1);
      alu_en_in = 1'b0; mul_en_in = 1'b0;
      #2 rstn = 1'b0;
      #1 chk_outputs_zero("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      idle();
      idle();
      chk("ar_post_en", 32'(wb_en_out), 32'd0);
      chk("ar_post_count", 32'(count_out), 32'd0);

      chk("sb_empty_end", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_wb_buf.md
# mul_wb_buf

Writeback buffer that sits directly downstream of the two-stage multiplier's final stage and shares the single integer register-file write port with the ALU. The ALU has priority on the port. Multiplier results that lose arbitration are held in a small in-order FIFO and retired when the port is free, so the fixed-latency multiplier never drops a result. The block raises a registered-state stall toward multiplier issue before the FIFO can overflow.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- SLACK, 2, multiplier ops that can still arrive after stall asserts (ops in flight in the 2 stages); must be < DEPTH.

- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all pending multiplier results.
- mul_en_in  in  1  multiplier result valid this cycle.
- mul_rd_in  in  5  destination register.
- mul_result_in  in  32  selected 32-bit product (low or high word, already chosen upstream).
- alu_en_in  in  1  ALU writeback request; always granted.
- alu_rd_in  in  5  ALU destination register.
- alu_result_in  in  32  ALU data.
- wb_en_out  out  1  register-file write enable (registered).
- wb_rd_out  out  5  write address (registered).
- wb_data_out  out  32  write data (registered).
- mul_stall_out  out  1  stop issuing new multiply ops.
- count_out  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_err  out  1  sticky error flag: an enqueue was attempted while the FIFO was full.

## Operation
- Enqueue candidate: mul_en_in=1 and mul_rd_in≠0. Results with rd=0 are silently dropped; they never enter the FIFO and are never written back.
- Port selection each cycle, in priority order:
  1. alu_en_in=1 → ALU. If the ALU has alu_rd_in=0, wb_en_out is still 0 next cycle.
  2. FIFO non-empty → oldest entry; it is dequeued.
  3. Enqueue candidate present → bypassed straight to the port, not stored.
  4. Otherwise wb_en_out=0 next cycle.
- An enqueue candidate not selected for the port is pushed at the FIFO tail in the same edge.
- Push and pop may occur together; count is unchanged in that case.
- Ordering: multiplier results retire strictly in arrival order. Bypass occurs only when the FIFO is empty.
- Full case: count=DEPTH, candidate present, ALU active → push is dropped and overflow_err is set. overflow_err stays 1 until reset.
- Full case without ALU: count=DEPTH, candidate present, ALU idle → pop plus push, no error.
- Flush: FIFO cleared (count→0, pointers reset). Any multiplier candidate in the same cycle is dropped and not bypassed. ALU selection that cycle proceeds normally. A wb_* value already registered is not cancelled.
- mul_stall_out = (count ≥ DEPTH−SLACK). It is decoded from registered count only; there is no combinational path from any input.
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH; overflow is reported, never wrapped.

## Timing
- Reset values: wb_en_out=0, wb_rd_out=0, wb_data_out=0, count_out=0, mul_stall_out=0, overflow_err=0. Pointers=0 and FIFO contents are don't-care.
- Latency, empty FIFO, ALU idle: mul_en_in at cycle N → wb_en_out=1 at cycle N+1.
- Latency, queued entry at position k (0 = head) with no ALU activity: written at cycle N+1+k relative to when it became eligible. Each ALU cycle adds one cycle.
- mul_stall_out reflects count after edge N. With SLACK=2, up to two further results arriving after stall asserts fit without overflow.
- Reset assertion mid-operation: all outputs go to reset values immediately (asynchronous); queued results are lost.
- Release of rstn is synchronized by the surrounding design; the block needs no internal synchronizer.

## Test plan
- Bypass: empty FIFO, ALU idle, mul_en_in=1, rd=5, data=0x12345678 at cycle 10 → cycle 11: wb_en_out=1, rd=5, data=0x12345678; count stays 0.
- Contention and ordering:
  - Stimulus: ALU writes rd=3 on cycles 10–12; multiplier delivers rd=7/0xA, rd=8/0xB, rd=9/0xC on cycles 10–12.
  - Cycles 11–13: ALU writes.
  - Cycles 14, 15, 16: rd 7, 8, 9 in that order.
  - count peaks at 3.
  - mul_stall_out=1 while count ≥ 2 (DEPTH=4, SLACK=2).
- rd=0 drop: mul_en_in=1, rd=0 with ALU idle → no write, count unchanged.
- Flush: count=3 and flush=1 together with mul_en_in=1, rd=4 → next cycle count=0, mul_stall_out=0, no multiplier write for any of the 4 results; a simultaneous ALU write rd=2 still appears.
- Overflow: fill to count=4, then alu_en_in=1 and mul_en_in=1 → overflow_err=1 and stays 1. Same fill with ALU idle → head written, new entry queued, count=4, overflow_err=0.
- Async reset: assert rstn=0 between edges with count=2 and wb_en_out=1 → all outputs 0 immediately, before the next clock edge.
